div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_div_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: fetches a 16-bit dividend and 8-bit divisor from data memory, computes
// floor(dividend*256/divisor) by restoring division and writes the 24-bit result back.
// Optional macro DIV_ZERO_FLAG_EN adds the sticky DivZero output.
//
// state  | meaning
// IDLE   | waiting for Start 1->0
// LOAD   | reading operands from addresses 0..2
// DIVIDE | 24 restoring-division steps, one quotient bit each
// STORE  | writing result bytes to addresses 4..6
// DONE   | Ack high until Start is seen high
module div_sequencer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] MemAddr,
  input  logic [7:0] MemRdData,
  output logic [7:0] MemWrData,
  output logic       MemWrEn
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic       DivZero
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DIVIDE = 3'd2,
    STORE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        start_q;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] dividend_q, dividend_d;
  logic [7:0]  divisor_q, divisor_d;
  logic [23:0] num_q, num_d;
  logic [8:0]  rem_q, rem_d;
  logic [23:0] quot_q, quot_d;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero_q, div_zero_d;
`endif

  logic        launch;
  logic [9:0]  rem_shift;
  logic [8:0]  rem_sub;
  logic        rem_ge;

  assign launch    = start_q & ~Start;
  assign rem_shift = {rem_q, num_q[23]};
  assign rem_ge    = (rem_shift >= {2'b00, divisor_q});
  assign rem_sub   = rem_shift[8:0] - {1'b0, divisor_q};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      num_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= Start;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      num_q      <= num_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_q <= div_zero_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    num_d      = num_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
`ifdef DIV_ZERO_FLAG_EN
    div_zero_d = div_zero_q;
`endif
    Ack        = 1'b0;
    MemAddr    = 8'h00;
    MemWrData  = 8'h00;
    MemWrEn    = 1'b0;

    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = LOAD;
          cnt_d   = 5'd2;
`ifdef DIV_ZERO_FLAG_EN
          div_zero_d = 1'b0;
`endif
        end
      end

      LOAD: begin
        MemAddr = 8'd2 - {3'b000, cnt_q};
        if (Start) begin
          state_d = IDLE;
        end else if (cnt_q == 5'd2) begin
          dividend_d[15:8] = MemRdData;
          cnt_d            = cnt_q - 5'd1;
        end else if (cnt_q == 5'd1) begin
          dividend_d[7:0] = MemRdData;
          cnt_d           = cnt_q - 5'd1;
        end else begin
          divisor_d = MemRdData;
          if (MemRdData == 8'h00) begin
            // Division by zero saturates the result and skips the divide loop.
            state_d = STORE;
            quot_d  = 24'hFFFFFF;
            cnt_d   = 5'd2;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_d = 1'b1;
`endif
          end else begin
            state_d = DIVIDE;
            num_d   = {dividend_q, 8'h00};
            rem_d   = '0;
            quot_d  = '0;
            cnt_d   = 5'd23;
          end
        end
      end

      DIVIDE: begin
        if (Start) begin
          state_d = IDLE;
        end else begin
          num_d = {num_q[22:0], 1'b0};
          if (rem_ge) begin
            rem_d  = rem_sub;
            quot_d = {quot_q[22:0], 1'b1};
          end else begin
            rem_d  = rem_shift[8:0];
            quot_d = {quot_q[22:0], 1'b0};
          end
          if (cnt_q == 5'd0) begin
            state_d = STORE;
            cnt_d   = 5'd2;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end

      STORE: begin
        MemWrEn = 1'b1;
        MemAddr = 8'd6 - {3'b000, cnt_q};
        if (cnt_q == 5'd2)      MemWrData = quot_q[23:16];
        else if (cnt_q == 5'd1) MemWrData = quot_q[15:8];
        else                    MemWrData = quot_q[7:0];
        if (Start) begin
          state_d = IDLE;
        end else if (cnt_q == 5'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      DONE: begin
        Ack = 1'b1;
        if (Start) begin
          state_d = IDLE;
        end else if (launch) begin
          state_d = LOAD;
          cnt_d   = 5'd2;
`ifdef DIV_ZERO_FLAG_EN
          div_zero_d = 1'b0;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef DIV_ZERO_FLAG_EN
  assign DivZero = div_zero_q;
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed runs of div_sequencer against a cycle-timeline model built
// from launch time, operand values and plain integer division.
module tb_div_sequencer;

  logic       Clk   = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       Ack, MemWrEn;
  logic [7:0] MemAddr, MemRdData, MemWrData;
`ifdef DIV_ZERO_FLAG_EN
  logic       DivZero;
`endif

  logic [7:0] op0 = 8'h00, op1 = 8'h00, op2 = 8'h00;
  logic [7:0] wmem [0:7];
  logic       preset_req = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // literal-check mailbox: written only by the stimulus, consumed by the compare process
  int    lit_req  = 0;
  int    lit_seen = 0;
  string lit_name = "";
  int    lit_act  = 0;
  int    lit_exp  = 0;

  // model state
  logic        m_busy = 1'b0, m_ack = 1'b0, m_prev = 1'b0, m_zero = 1'b0, m_dz = 1'b0;
  int          m_t = 0;
  logic [23:0] m_res = '0;
  logic [15:0] m_dd;

  div_sequencer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .MemAddr   (MemAddr),
    .MemRdData (MemRdData),
    .MemWrData (MemWrData),
    .MemWrEn   (MemWrEn)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .DivZero   (DivZero)
`endif
  );

  always #5 Clk = ~Clk;

  assign MemRdData = (MemAddr == 8'd0) ? op0 :
                     (MemAddr == 8'd1) ? op1 :
                     (MemAddr == 8'd2) ? op2 : 8'h00;

  always @(posedge Clk) begin
    if (preset_req) begin
      for (int i = 0; i < 8; i++) wmem[i] <= 8'hA5;
    end else if (MemWrEn && MemAddr < 8'd8) begin
      wmem[MemAddr[2:0]] <= MemWrData;
    end
  end

  // Timeline model: a run is m_t cycles old; LOAD is 3 cycles, DIVIDE 24 (absent for /0), STORE 3.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_busy = 1'b0; m_ack = 1'b0; m_prev = 1'b0; m_t = 0; m_dz = 1'b0;
    end else begin
      if (m_busy) begin
        if (Start) begin
          m_busy = 1'b0;
        end else begin
          m_t++;
          if (m_zero && m_t == 3) m_dz = 1'b1;
          if (m_t == (m_zero ? 6 : 30)) begin
            m_busy = 1'b0;
            m_ack  = 1'b1;
          end
        end
      end else if (m_ack && Start) begin
        m_ack = 1'b0;
      end else if (m_prev && !Start) begin
        m_busy = 1'b1; m_ack = 1'b0; m_t = 0; m_dz = 1'b0;
        m_dd   = {op0, op1};
        m_zero = (op2 == 8'h00);
        m_res  = m_zero ? 24'hFFFFFF : 24'((int'(m_dd) * 256) / int'(op2));
      end
      m_prev = Start;
    end
  end

  logic       e_we;
  logic [7:0] e_addr, e_data;
  int         e_s;
  logic       dz_bad;

  always @(negedge Clk) begin
    e_we = 1'b0; e_addr = 8'h00; e_data = 8'h00;
    if (m_busy) begin
      e_s = m_zero ? 3 : 27;
      if (m_t < 3) begin
        e_addr = 8'(m_t);
      end else if (m_t >= e_s) begin
        e_we   = 1'b1;
        e_addr = 8'(4 + m_t - e_s);
        case (m_t - e_s)
          0:       e_data = m_res[23:16];
          1:       e_data = m_res[15:8];
          default: e_data = m_res[7:0];
        endcase
      end
    end
    dz_bad = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
    dz_bad = (DivZero !== m_dz);
`endif
    n_vec++;
    if (Ack !== m_ack || MemWrEn !== e_we || MemAddr !== e_addr || MemWrData !== e_data || dz_bad) begin
      n_err++;
      $display("FAIL cycle_check t=%0t got Ack=%b WrEn=%b Addr=%0h Data=%0h want Ack=%b WrEn=%b Addr=%0h Data=%0h dz_bad=%b",
               $time, Ack, MemWrEn, MemAddr, MemWrData, m_ack, e_we, e_addr, e_data, dz_bad);
    end
    if (lit_req != lit_seen) begin
      lit_seen = lit_req;
      n_vec++;
      if (lit_act != lit_exp) begin
        n_err++;
        $display("FAIL %s got %0h want %0h", lit_name, lit_act, lit_exp);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp_v);
    lit_name = nm;
    lit_act  = act;
    lit_exp  = exp_v;
    lit_req++;
    @(negedge Clk);
    #1;
  endtask

  task automatic preset();
    preset_req = 1'b1;
    @(negedge Clk);
    #1;
    preset_req = 1'b0;
  endtask

  task automatic start_pulse(input logic [15:0] dd, input logic [7:0] dv);
    op0 = dd[15:8]; op1 = dd[7:0]; op2 = dv;
    Start = 1'b1;
    repeat (2) @(negedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_ack(output int lat);
    @(posedge Clk);
    lat = 0;
    while (lat < 100) begin
      @(posedge Clk);
      lat++;
      #1;
      if (Ack) break;
    end
  endtask

  task automatic check_run(input string tag, input int lat, input int exp_lat,
                           input logic [23:0] exp_res, input logic exp_dz);
    lit({tag, "_latency"}, lat, exp_lat);
    lit({tag, "_model_res"}, int'(m_res), int'(exp_res));
    lit({tag, "_model_dz"}, int'(m_dz), int'(exp_dz));
    lit({tag, "_byte4"}, int'(wmem[4]), int'(exp_res[23:16]));
    lit({tag, "_byte5"}, int'(wmem[5]), int'(exp_res[15:8]));
    lit({tag, "_byte6"}, int'(wmem[6]), int'(exp_res[7:0]));
    lit({tag, "_ack_held"}, int'(Ack), 1);
`ifdef DIV_ZERO_FLAG_EN
    lit({tag, "_divzero"}, int'(DivZero), int'(exp_dz));
`endif
  endtask

  task automatic run(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                     input int exp_lat, input logic [23:0] exp_res, input logic exp_dz);
    int lat;
    preset();
    start_pulse(dd, dv);
    wait_ack(lat);
    check_run(tag, lat, exp_lat, exp_res, exp_dz);
  endtask

  initial begin
    int   lat;
    logic c_ack, c_we;
    logic [7:0] c_addr, c_data;

    repeat (2) @(negedge Clk);
    #1;
    lit("reset_ack", int'(Ack), 0);
    lit("reset_addr", int'(MemAddr), 0);
    lit("reset_wren", int'(MemWrEn), 0);
    Reset = 1'b1;
    preset();

    run("div_12800_25", 16'h3200, 8'h19, 30, 24'h020000, 1'b0);
    run("div_385_6",    16'h0181, 8'h06, 30, 24'h00402A, 1'b0);
    run("div_zero",     16'h1234, 8'h00, 6,  24'hFFFFFF, 1'b1);
    run("div_ffff_1",   16'hFFFF, 8'h01, 30, 24'hFFFF00, 1'b0);
    run("div_1_ff",     16'h0001, 8'hFF, 30, 24'h000001, 1'b0);

    // abort in DIVIDE cycle 10, then relaunch with Start held high in between
    preset();
    start_pulse(16'h3200, 8'h19);
    @(posedge Clk);
    repeat (12) @(posedge Clk);
    @(negedge Clk);
    #1;
    Start = 1'b1;
    repeat (4) @(negedge Clk);
    #1;
    lit("abort_ack", int'(Ack), 0);
    lit("abort_byte4", int'(wmem[4]), 'hA5);
    lit("abort_byte5", int'(wmem[5]), 'hA5);
    lit("abort_byte6", int'(wmem[6]), 'hA5);
    Start = 1'b0;
    wait_ack(lat);
    check_run("relaunch", lat, 30, 24'h020000, 1'b0);

    // reset pulse mid-DIVIDE
    preset();
    start_pulse(16'hFFFF, 8'h01);
    @(posedge Clk);
    repeat (10) @(posedge Clk);
    #3;
    Reset = 1'b0;
    #1;
    c_ack = Ack; c_we = MemWrEn; c_addr = MemAddr; c_data = MemWrData;
    lit("rst_mid_ack", int'(c_ack), 0);
    lit("rst_mid_wren", int'(c_we), 0);
    lit("rst_mid_addr", int'(c_addr), 0);
    lit("rst_mid_data", int'(c_data), 0);
    Reset = 1'b1;
    repeat (40) @(negedge Clk);
    #1;
    lit("rst_no_launch_ack", int'(Ack), 0);
    lit("rst_byte4", int'(wmem[4]), 'hA5);
    lit("rst_byte5", int'(wmem[5]), 'hA5);
    lit("rst_byte6", int'(wmem[6]), 'hA5);

    run("after_reset", 16'h0181, 8'h06, 30, 24'h00402A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
